// File: rtl/bitpos_assembler.sv
// bitpos_assembler
//   Rebuilds a 32-bit word from a stream of 1-based bit positions. A position
//   p in 1..32 means bit p-1. A position of 0 means "no bit" and changes
//   nothing. The block receives one position per beat over a valid/ready
//   handshake. When the beat marked last is accepted, it holds the assembled
//   word, its set-bit count and sticky error flags until the consumer takes
//   them.
//
// Parameters
//   ORDER_CHECK : 1 enables the strictly-ascending position check,
//                 0 ties out_order low.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low
//   in_valid   : position beat present
//   in_ready   : block can accept a beat (high only while collecting)
//   in_pos     : position 0..63 (1..32 legal bits, 0 = none)
//   in_last    : beat closes the word
//   out_valid  : result held
//   out_ready  : consumer takes the result
//   out_word   : assembled word
//   out_count  : number of distinct bits set, 0..32
//   out_dup    : a position repeated within the word
//   out_range  : a position in 33..63 was received
//   out_order  : a nonzero position was not above the previous nonzero one
module bitpos_assembler #(
  parameter bit ORDER_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_pos,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_count,
  output logic        out_dup,
  output logic        out_range,
  output logic        out_order
);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t     state;
  logic [5:0] prev_pos;
  logic       prev_vld;

  logic       pos_legal;
  logic [4:0] bit_idx;
  logic       bit_hit;

  // Bit index is taken modulo 32, so position 32 maps to 0 - 1 = 31
  // without needing a sixth index bit.
  always_comb begin
    pos_legal = (in_pos != 6'd0) && (in_pos <= 6'd32);
    bit_idx   = in_pos[4:0] - 5'd1;
    bit_hit   = out_word[bit_idx];
  end

  // Handshake flags decode straight from the state register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= COLLECT;
      out_word  <= '0;
      out_count <= '0;
      out_dup   <= 1'b0;
      out_range <= 1'b0;
      out_order <= 1'b0;
      prev_pos  <= '0;
      prev_vld  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (pos_legal) begin
              // A repeated bit raises dup but is not counted again, which
              // keeps the count within 0..32.
              if (bit_hit) begin
                out_dup <= 1'b1;
              end else begin
                out_word[bit_idx] <= 1'b1;
                out_count         <= out_count + 6'd1;
              end
              if (ORDER_CHECK && prev_vld && (in_pos <= prev_pos)) begin
                out_order <= 1'b1;
              end
              prev_pos <= in_pos;
              prev_vld <= 1'b1;
            end else if (in_pos != 6'd0) begin
              out_range <= 1'b1;
            end
            if (in_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= COLLECT;
            out_word  <= '0;
            out_count <= '0;
            out_dup   <= 1'b0;
            out_range <= 1'b0;
            out_order <= 1'b0;
            prev_vld  <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
